// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered 2**N-to-N priority encoder with a fixed-priority
// mode (highest index wins) and a round-robin mode (last granted index drops to
// lowest priority). The result is held under a valid/ready handshake.
// Optional feature macro: RR_ONEHOT_OUT_EN adds a registered one-hot copy of
// the granted index (out_onehot).
module rr_priority_encoder #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [(1<<N)-1:0]  req,
  output logic [N-1:0]       out_idx,
  output logic               out_valid,
  input  logic               out_ready
`ifdef RR_ONEHOT_OUT_EN
  ,
  output logic [(1<<N)-1:0]  out_onehot
`endif
);

  localparam int W = 1 << N;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [N-1:0]   ptr;

  logic           handshake_p0;
  logic           capture_p0;
  logic [N-1:0]   ptr_eff_p0;
  logic [N-1:0]   winner_p0;

  // Search starts at (p-1) mod W and descends with wrap-around; p=0 gives the
  // plain highest-index-first order used by fixed mode.
  function automatic logic [N-1:0] pick(input logic [W-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] start;
    logic [N-1:0] idx;
    logic         found;
    start = p - 1'b1;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      idx = start - N'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Stage p0: handshake detect, pointer bypass and winner search.
  always_comb begin
    handshake_p0 = (state == FULL) && out_ready;
    // A round-robin handshake moves ptr to out_idx this edge; the same-cycle
    // capture must already search from that new value.
    ptr_eff_p0   = (handshake_p0 && mode) ? out_idx : ptr;
    capture_p0   = enable && (req != '0) && ((state == EMPTY) || handshake_p0);
    winner_p0    = mode ? pick(req, ptr_eff_p0) : pick(req, '0);
  end

  // Stage p1: result register, handshake state machine and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
`ifdef RR_ONEHOT_OUT_EN
      out_onehot <= '0;
`endif
    end else begin
      if (handshake_p0 && mode)
        ptr <= out_idx;
      if (capture_p0) begin
        state      <= FULL;
        out_idx    <= winner_p0;
        out_valid  <= 1'b1;
`ifdef RR_ONEHOT_OUT_EN
        out_onehot <= W'(1) << winner_p0;
`endif
      end else if (handshake_p0) begin
        state      <= EMPTY;
        out_valid  <= 1'b0;
`ifdef RR_ONEHOT_OUT_EN
        out_onehot <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder (N=3): a per-cycle vector table for
// reset, fixed mode, round-robin rotation, backpressure and boundaries, plus a
// hand-written sequence for the one-hot output.
module tb_rr_priority_encoder;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         mode;
  logic [7:0]   req;
  logic [N-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
`ifdef RR_ONEHOT_OUT_EN
  logic [7:0]   out_onehot;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rr_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_ONEHOT_OUT_EN
    ,
    .out_onehot(out_onehot)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       rdy;
    logic       exp_v;
    logic [2:0] exp_idx;
    logic [2:0] exp_ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic [7:0] q, input logic y);
    @(negedge clk);
    rst_n = r; enable = e; mode = m; req = q; out_ready = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; req = '0; out_ready = 1'b0;

    //                rst en md req         rdy  v  idx ptr
    // reset held with all requests pending, then first result
    tbl.push_back('{1'b0,1'b1,1'b0,8'hFF,      1'b0,1'b0,3'd0,3'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'hFF,      1'b0,1'b0,3'd0,3'd0});
    tbl.push_back('{1'b1,1'b1,1'b0,8'hFF,      1'b0,1'b1,3'd7,3'd0});
    // fixed mode back-to-back
    tbl.push_back('{1'b1,1'b1,1'b0,8'b00100100,1'b1,1'b1,3'd5,3'd0});
    tbl.push_back('{1'b1,1'b1,1'b0,8'b00100100,1'b1,1'b1,3'd5,3'd0});
    tbl.push_back('{1'b1,1'b1,1'b0,8'b00100100,1'b1,1'b1,3'd5,3'd0});
    // drain, then round-robin rotation 5,2,5,2
    tbl.push_back('{1'b1,1'b0,1'b0,8'b00100100,1'b1,1'b0,3'd5,3'd0});
    tbl.push_back('{1'b1,1'b1,1'b1,8'b00100100,1'b1,1'b1,3'd5,3'd0});
    tbl.push_back('{1'b1,1'b1,1'b1,8'b00100100,1'b1,1'b1,3'd2,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b1,8'b00100100,1'b1,1'b1,3'd5,3'd2});
    tbl.push_back('{1'b1,1'b1,1'b1,8'b00100100,1'b1,1'b1,3'd2,3'd5});
    // fixed-mode handshake leaves ptr alone; backpressure holds idx 6
    tbl.push_back('{1'b1,1'b0,1'b0,8'b00100100,1'b1,1'b0,3'd2,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h40,      1'b0,1'b1,3'd6,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h01,      1'b0,1'b1,3'd6,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h01,      1'b0,1'b1,3'd6,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h01,      1'b0,1'b1,3'd6,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h01,      1'b0,1'b1,3'd6,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h01,      1'b1,1'b1,3'd0,3'd5});
    // enable=0 completes the handshake but blocks capture
    tbl.push_back('{1'b1,1'b0,1'b0,8'hFF,      1'b1,1'b0,3'd0,3'd5});
    tbl.push_back('{1'b1,1'b0,1'b0,8'hFF,      1'b0,1'b0,3'd0,3'd5});
    // req=0 drops valid only after the pending handshake
    tbl.push_back('{1'b1,1'b1,1'b0,8'h10,      1'b0,1'b1,3'd4,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h00,      1'b0,1'b1,3'd4,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h00,      1'b1,1'b0,3'd4,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b0,8'h00,      1'b1,1'b0,3'd4,3'd5});
    // round-robin capture from saved ptr 5, stall, then reset while FULL
    tbl.push_back('{1'b1,1'b1,1'b1,8'h08,      1'b0,1'b1,3'd3,3'd5});
    tbl.push_back('{1'b1,1'b1,1'b1,8'h08,      1'b0,1'b1,3'd3,3'd5});
    tbl.push_back('{1'b0,1'b1,1'b1,8'h08,      1'b0,1'b0,3'd0,3'd0});
    tbl.push_back('{1'b1,1'b0,1'b1,8'h08,      1'b0,1'b0,3'd0,3'd0});

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].req, tbl[i].rdy);
      chk($sformatf("row%0d out_valid", i), int'(out_valid), int'(tbl[i].exp_v));
      chk($sformatf("row%0d out_idx", i),   int'(out_idx),   int'(tbl[i].exp_idx));
      chk($sformatf("row%0d ptr", i),       int'(dut.ptr),   int'(tbl[i].exp_ptr));
    end

    // One-hot sequence: round-robin over requests 7 and 0.
    drive(1'b0, 1'b0, 1'b1, 8'h81, 1'b1);
`ifdef RR_ONEHOT_OUT_EN
    chk("oh reset", int'(out_onehot), 8'h00);
`endif
    drive(1'b1, 1'b1, 1'b1, 8'h81, 1'b1);
    chk("oh seq0 idx", int'(out_idx), 7);
`ifdef RR_ONEHOT_OUT_EN
    chk("oh seq0 onehot", int'(out_onehot), 8'h80);
`endif
    drive(1'b1, 1'b1, 1'b1, 8'h81, 1'b1);
    chk("oh seq1 idx", int'(out_idx), 0);
`ifdef RR_ONEHOT_OUT_EN
    chk("oh seq1 onehot", int'(out_onehot), 8'h01);
`endif
    drive(1'b1, 1'b1, 1'b1, 8'h81, 1'b1);
    chk("oh seq2 idx", int'(out_idx), 7);
    chk("oh seq2 valid", int'(out_valid), 1);
`ifdef RR_ONEHOT_OUT_EN
    chk("oh seq2 onehot", int'(out_onehot), 8'h80);
`endif
    drive(1'b1, 1'b0, 1'b1, 8'h81, 1'b1);
    chk("oh drain valid", int'(out_valid), 0);
`ifdef RR_ONEHOT_OUT_EN
    chk("oh drain onehot", int'(out_onehot), 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Registered, parametrised successor to the combinational N-bit priority encoder.
- Encodes 2**N request lines to an N-bit index in one of two modes:
  - fixed priority: highest index wins;
  - round-robin: the last granted index drops to lowest priority.
- Result is held in an output register with a valid/ready handshake, so it can feed pipelined consumers such as bus arbiters and interrupt dispatchers.

Parameters:
- N, 3, index width; request vector width is 2**N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  input  1  allows capture of a new result when high.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  2**N  request vector, one bit per source.
- out_idx  output  N  encoded index of the granted request (registered).
- out_valid  output  1  out_idx holds an unconsumed result.
- out_ready  input  1  consumer accepts out_idx this cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_idx=0, out_valid=0, ptr=0, state=EMPTY. Reset mid-handshake discards the pending result; no partial state survives.
- ptr is an internal N-bit round-robin pointer. Search order starts at index (ptr-1) mod 2**N and descends with wrap-around. With ptr=0 the order starts at 2**N-1, identical to fixed priority.
- Fixed mode: the winner is the highest set bit of req; ptr is ignored and not updated.
- State machine, two states:
  - EMPTY: out_valid=0. If enable=1 and req!=0, capture the winner into out_idx → FULL. Otherwise stay.
  - FULL: out_valid=1, out_idx held stable.
    - out_ready=0: stay, regardless of req/enable changes.
    - out_ready=1 (handshake), round-robin mode: ptr <= out_idx.
    - out_ready=1, enable=1, req!=0: capture the next winner in the same cycle and stay FULL. Back-to-back throughput is 1 per cycle; the search uses the pre-update ptr plus a same-cycle bypass of the new ptr value.
    - out_ready=1, otherwise: → EMPTY.
- Latency: req sampled at edge k gives out_valid/out_idx visible after edge k. One-cycle latency.
- req=0 never produces a result; there is no "zero" code on out_idx.
- Switching mode takes effect at the next capture. ptr keeps its value while in fixed mode.
- req is sampled only at a capture. Changes while FULL and stalled are ignored until the handshake.
- enable=0 blocks new captures only; a pending result still completes its handshake.
- ptr wraps naturally modulo 2**N; no overflow flag.

Optional Feature:
- Macro RR_ONEHOT_OUT_EN.
- Defined: adds output port out_onehot [2**N-1:0], registered alongside out_idx, equal to 1<<out_idx while out_valid=1 and 0 otherwise; reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
All scenarios use N=3.
1. Reset: hold rst_n=0 for 2 cycles with req=8'hFF, enable=1 → out_valid=0, out_idx=0 throughout; first result appears one cycle after rst_n=1 with out_idx=7.
2. Fixed mode: mode=0, req=8'b0010_0100, out_ready=1 held → out_idx=5 every cycle, back-to-back; ptr unchanged at 0.
3. Round-robin rotation: mode=1, req=8'b0010_0100 constant, out_ready=1 → grant sequence 5, 2, 5, 2 (wrap-around from index 1 to 7 exercised).
4. Backpressure: out_valid=1, out_idx=6, out_ready=0 for 4 cycles while req changes to 8'h01 → out_idx stays 6, ptr unchanged; on out_ready=1, next result is 0.
5. Boundaries: enable=0 with req=8'hFF → no capture. req=0 with enable=1 → out_valid drops to 0 after the pending handshake. Reset asserted while FULL and stalled → out_valid=0 on the next edge, ptr=0.
6. With RR_ONEHOT_OUT_EN defined: mode=1, req=8'b1000_0001 → out_idx 7, 0, 7 with out_onehot 8'h80, 8'h01, 8'h80. out_onehot=0 whenever out_valid=0.
